ascon_ctrl_fsm: RTL and testbench

Sequencing controller for the ASCON-128 permutation datapath (`permutation_v4`). It drives the datapath control inputs through the four phases of an encryption:
- initialisation, p^12;
- associated data, p^6 per block;
- plaintext, p^6 per block;
- finalisation, p^12.

It also exposes a valid/ready handshake to the block source that supplies `data_i`. It sits between the top-level ASCON wrapper and the permutation instance.

---
 rtl/ascon_pack.sv | 18 +
 rtl/round_counter.sv | 44 ++++
 rtl/ascon_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON-128 sequencing controller.
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6
    } type_ctrl_state;

    localparam logic [3:0] ROUND_FIRST_A = 4'd0;
    localparam logic [3:0] ROUND_FIRST_B = 4'd6;
    localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/round_counter.sv
// 4-bit round counter with load/increment and a registered terminal-round flag.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       increment,
    output logic [3:0] count,
    output logic       last
);

    logic [3:0] count_r;
    logic       last_r;
    logic [3:0] next_count_s;

    // Next count: load wins over increment.
    always_comb begin
        next_count_s = count_r;
        if (load) begin
            next_count_s = load_value;
        end else if (increment) begin
            next_count_s = count_r + 4'd1;
        end else begin
            next_count_s = count_r;
        end
    end

    // Count register and flag computed from the next value so both update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 4'd0;
            last_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            last_r  <= (next_count_s == ROUND_LAST);
        end
    end

    assign count = count_r;
    assign last  = last_r;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Phase sequencer for the ASCON-128 permutation datapath with a valid/ready block source.
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       select_o,
    output logic       enable_o,
    output logic       xor_data_begin_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_ext_end_o,
    output logic       enable_cipher_o,
    output logic       enable_tag_o,
    output logic       busy_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o
);

    // Every phase finishes on ROUND_LAST, so the first round follows from the phase length.
    localparam logic [3:0] FIRST_A      = 4'(ROUND_LAST + 4'd1 - 4'(ROUNDS_A));
    localparam logic [3:0] FIRST_B      = 4'(ROUND_LAST + 4'd1 - 4'(ROUNDS_B));
    localparam logic [3:0] FIRST_A_NEXT = 4'(FIRST_A + 4'd1);

    type_ctrl_state state_r;
    type_ctrl_state next_state_s;
    logic           ad_last_r;
    logic           cipher_valid_r;
    logic           tag_valid_r;

    logic       load_s;
    logic [3:0] load_value_s;
    logic       inc_s;
    logic [3:0] count_s;
    logic       last_s;

    logic       ready_s;
    logic [3:0] round_s;
    logic       select_s;
    logic       enable_s;
    logic       xdb_s;
    logic       xkb_s;
    logic       xke_s;
    logic       xee_s;
    logic       enc_s;
    logic       ent_s;

    round_counter u_round_counter (
        .clock      (clock_i),
        .reset      (reset_i),
        .load       (load_s),
        .load_value (load_value_s),
        .increment  (inc_s),
        .count      (count_s),
        .last       (last_s)
    );

    // Next state, counter control and datapath controls (Mealy in the wait states).
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_value_s = FIRST_A;
        inc_s        = 1'b0;
        ready_s      = 1'b0;
        round_s      = count_s;
        select_s     = 1'b1;
        enable_s     = 1'b0;
        xdb_s        = 1'b0;
        xkb_s        = 1'b0;
        xke_s        = 1'b0;
        xee_s        = 1'b0;
        enc_s        = 1'b0;
        ent_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                round_s  = 4'd0;
                select_s = 1'b0;
                if (start_i) begin
                    next_state_s = ST_INIT;
                    load_s       = 1'b1;
                    load_value_s = FIRST_A;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                enable_s = 1'b1;
                select_s = (count_s != FIRST_A);
                if (last_s) begin
                    xke_s        = 1'b1;
                    next_state_s = ST_WAIT_AD;
                    load_s       = 1'b1;
                    load_value_s = FIRST_B;
                end else begin
                    inc_s = 1'b1;
                end
            end
            ST_WAIT_AD: begin
                round_s = FIRST_B;
                if (data_valid_i) begin
                    ready_s      = 1'b1;
                    enable_s     = 1'b1;
                    xdb_s        = 1'b1;
                    inc_s        = 1'b1;
                    next_state_s = ST_AD;
                end else begin
                    next_state_s = ST_WAIT_AD;
                end
            end
            ST_AD, ST_PT: begin
                enable_s = 1'b1;
                if (last_s) begin
                    load_s       = 1'b1;
                    load_value_s = FIRST_B;
                    if (state_r == ST_AD) begin
                        xee_s        = ad_last_r;
                        next_state_s = ad_last_r ? ST_WAIT_PT : ST_WAIT_AD;
                    end else begin
                        next_state_s = ST_WAIT_PT;
                    end
                end else begin
                    inc_s = 1'b1;
                end
            end
            ST_WAIT_PT: begin
                round_s = FIRST_B;
                if (data_valid_i) begin
                    ready_s  = 1'b1;
                    enable_s = 1'b1;
                    xdb_s    = 1'b1;
                    enc_s    = 1'b1;
                    if (data_last_i) begin
                        // The last plaintext cycle doubles as round 0 of finalisation.
                        round_s      = FIRST_A;
                        xkb_s        = 1'b1;
                        load_s       = 1'b1;
                        load_value_s = FIRST_A_NEXT;
                        next_state_s = ST_FINAL;
                    end else begin
                        inc_s        = 1'b1;
                        next_state_s = ST_PT;
                    end
                end else begin
                    next_state_s = ST_WAIT_PT;
                end
            end
            ST_FINAL: begin
                enable_s = 1'b1;
                if (last_s) begin
                    xke_s        = 1'b1;
                    ent_s        = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    inc_s = 1'b1;
                end
            end
            default: begin
                round_s      = 4'd0;
                select_s     = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, AD-last latch and the one-cycle valid pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= ST_IDLE;
            ad_last_r      <= 1'b0;
            cipher_valid_r <= 1'b0;
            tag_valid_r    <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            cipher_valid_r <= enc_s;
            tag_valid_r    <= ent_s;
            if ((state_r == ST_WAIT_AD) && data_valid_i) begin
                ad_last_r <= data_last_i;
            end
        end
    end

    assign data_ready_o     = ready_s;
    assign round_o          = round_s;
    assign select_o         = select_s;
    assign enable_o         = enable_s;
    assign xor_data_begin_o = xdb_s;
    assign xor_key_begin_o  = xkb_s;
    assign xor_key_end_o    = xke_s;
    assign xor_ext_end_o    = xee_s;
    assign enable_cipher_o  = enc_s;
    assign enable_tag_o     = ent_s;
    assign busy_o           = (state_r != ST_IDLE);
    assign cipher_valid_o   = cipher_valid_r;
    assign tag_valid_o      = tag_valid_r;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Randomized bench: per-cycle expected outputs come from a phase-level trace built from the protocol rules.
module tb_ascon_ctrl_fsm;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       data_valid_i;
    logic       data_last_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       select_o;
    logic       enable_o;
    logic       xor_data_begin_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       xor_ext_end_o;
    logic       enable_cipher_o;
    logic       enable_tag_o;
    logic       busy_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic [15:0] dut_vec;

    always #5 clock_i = ~clock_i;

    ascon_ctrl_fsm dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .data_valid_i     (data_valid_i),
        .data_last_i      (data_last_i),
        .data_ready_o     (data_ready_o),
        .round_o          (round_o),
        .select_o         (select_o),
        .enable_o         (enable_o),
        .xor_data_begin_o (xor_data_begin_o),
        .xor_key_begin_o  (xor_key_begin_o),
        .xor_key_end_o    (xor_key_end_o),
        .xor_ext_end_o    (xor_ext_end_o),
        .enable_cipher_o  (enable_cipher_o),
        .enable_tag_o     (enable_tag_o),
        .busy_o           (busy_o),
        .cipher_valid_o   (cipher_valid_o),
        .tag_valid_o      (tag_valid_o)
    );

    assign dut_vec = {data_ready_o, round_o, select_o, enable_o, xor_data_begin_o,
                      xor_key_begin_o, xor_key_end_o, xor_ext_end_o, enable_cipher_o,
                      enable_tag_o, busy_o, cipher_valid_o, tag_valid_o};

    typedef struct packed {
        logic        st;
        logic        dv;
        logic        dl;
        logic [15:0] exp;
    } step_t;

    step_t tr[$];
    int    err_cnt = 0;
    int    chk_cnt = 0;
    int    start_pos = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic st, input logic dv, input logic dl, input logic rdy,
                        input logic [3:0] rnd, input logic sel, input logic en, input logic xdb,
                        input logic xkb, input logic xke, input logic xee, input logic enc,
                        input logic ent, input logic busy);
        step_t s;
        s.st  = st;
        s.dv  = dv;
        s.dl  = dl;
        s.exp = {rdy, rnd, sel, en, xdb, xkb, xke, xee, enc, ent, busy, 2'b00};
        tr.push_back(s);
    endtask

    task automatic gen_idle(input int n, input logic do_start);
        logic st;
        for (int i = 0; i < n; i++) begin
            st = do_start && (i == n - 1);
            if (st) start_pos = tr.size();
            push(st, rb(), rb(), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic gen_block(input logic is_pt, input logic last, input int stall);
        for (int s = 0; s < stall; s++)
            push(rb(), 1'b0, is_pt ? 1'b0 : rb(), 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (is_pt && last) begin
            push(rb(), 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            for (int r = 1; r <= 11; r++)
                push(rb(), rb(), rb(), 1'b0, 4'(r), 1'b1, 1'b1, 1'b0, 1'b0, r == 11, 1'b0, 1'b0, r == 11, 1'b1);
        end else begin
            push(rb(), 1'b1, last, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, is_pt, 1'b0, 1'b1);
            for (int r = 7; r <= 11; r++)
                push(rb(), rb(), rb(), 1'b0, 4'(r), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                     !is_pt && last && (r == 11), 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic gen_op(input int n_ad, input int n_pt, input int smin, input int smax);
        for (int r = 0; r <= 11; r++)
            push(rb(), rb(), rb(), 1'b0, 4'(r), r != 0, 1'b1, 1'b0, 1'b0, r == 11, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < n_ad; b++)
            gen_block(1'b0, b == n_ad - 1, int'($urandom_range(smin, smax)));
        for (int b = 0; b < n_pt; b++)
            gen_block(1'b1, b == n_pt - 1, int'($urandom_range(smin, smax)));
    endtask

    task automatic run_trace(output int n_cv, output int n_xee, output int lat);
        logic pcv;
        logic ptv;
        pcv = 1'b0; ptv = 1'b0; n_cv = 0; n_xee = 0; lat = -1;
        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clock_i); #1;
            start_i = tr[i].st; data_valid_i = tr[i].dv; data_last_i = tr[i].dl;
            @(negedge clock_i);
            check_eq($sformatf("step%0d", i), 32'(dut_vec), 32'({tr[i].exp[15:2], pcv, ptv}));
            if (cipher_valid_o) n_cv++;
            if (xor_ext_end_o) n_xee++;
            if (tag_valid_o && lat < 0 && i >= start_pos) lat = i - start_pos + 1;
            pcv = tr[i].exp[4];
            ptv = tr[i].exp[3];
        end
        start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
        tr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cv, n_xee, lat, tv_cnt, busy_cnt, exp_cv, n_ops;
        logic found;
        reset_i = 1'b1; start_i = 1'b1; data_valid_i = 1'b1; data_last_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check_eq("rst_outs", 32'(dut_vec), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0; start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_i);
            check_eq("idle_hold", 32'(dut_vec), 32'd0);
        end

        // one AD block and one last PT block, no stalls
        gen_idle(2, 1'b1); gen_op(1, 1, 0, 0); gen_idle(3, 1'b0);
        run_trace(n_cv, n_xee, lat);
        check_eq("latency", 32'(lat), 32'(12 + 6 * 1 + 6 * (1 - 1) + 12 + 2));
        check_eq("s1_cv", 32'(n_cv), 32'd1);
        check_eq("s1_xee", 32'(n_xee), 32'd1);

        // back-pressure: five stall cycles before every block
        gen_idle(1, 1'b1); gen_op(1, 2, 5, 5); gen_idle(3, 1'b0);
        run_trace(n_cv, n_xee, lat);
        check_eq("bp_cv", 32'(n_cv), 32'd2);

        // two AD blocks, three PT blocks
        gen_idle(2, 1'b1); gen_op(2, 3, 0, 0); gen_idle(3, 1'b0);
        run_trace(n_cv, n_xee, lat);
        check_eq("s3_cv", 32'(n_cv), 32'd3);
        check_eq("s3_xee", 32'(n_xee), 32'd1);

        // abort in AD round 8
        @(posedge clock_i); #1; start_i = 1'b1;
        @(posedge clock_i); #1; start_i = 1'b0; data_valid_i = 1'b1; data_last_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock_i);
            if (xor_data_begin_o) found = 1'b1;
        end
        check_eq("abort_reach", 32'(found), 32'd1);
        @(posedge clock_i);
        @(posedge clock_i);
        @(negedge clock_i);
        check_eq("abort_round", 32'(round_o), 32'd8);
        reset_i = 1'b1;
        #1;
        check_eq("abort_outs", 32'(dut_vec), 32'd0);
        @(negedge clock_i);
        reset_i = 1'b0; data_valid_i = 1'b0;
        tv_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_i);
            if (tag_valid_o) tv_cnt++;
            if (busy_o) busy_cnt++;
        end
        check_eq("abort_no_tag", 32'(tv_cnt), 32'd0);
        check_eq("abort_idle", 32'(busy_cnt), 32'd0);

        // random back-to-back operations, gap 1 means start in the tag cycle
        exp_cv = 0; n_ops = 6;
        for (int k = 0; k < n_ops; k++) begin
            int na, np;
            na = int'($urandom_range(1, 3));
            np = int'($urandom_range(1, 3));
            exp_cv += np;
            gen_idle(int'($urandom_range(1, 3)), 1'b1);
            gen_op(na, np, 0, 3);
        end
        gen_idle(3, 1'b0);
        run_trace(n_cv, n_xee, lat);
        check_eq("rnd_cv", 32'(n_cv), 32'(exp_cv));
        check_eq("rnd_xee", 32'(n_xee), 32'(n_ops));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
